// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: command encodings, default widths
// and the memory access unit state type.
package mem_bus_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam int MAU_ADDR_W = 9;
    localparam int MAU_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        WR,
        RESP
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit: one load/store at a time from the core onto the
// memory command bus, response returned on a valid/ready port.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_we/
// req_addr/req_wdata (request); rsp_valid/rsp_ready/rsp_rdata (response);
// mem_cmd/mem_addr/write_data/read_data (memory bus).
module mem_access_unit
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = MAU_ADDR_W,
    parameter int DATA_W   = MAU_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    mau_state_t        state_q, state_d;
    logic [1:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        mem_cmd   = MNONE;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = req_we ? WR : RD_ADDR;
            end
            RD_ADDR: begin
                mem_cmd = MREAD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // keep MREAD so the responder keeps driving the bus
                mem_cmd = MREAD;
                if (cnt_q == 2'd0)
                    state_d = RESP;
            end
            WR: begin
                mem_cmd = MWRITE;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                RD_ADDR: cnt_q <= 2'(READ_LAT - 1);
                RD_WAIT: begin
                    if (cnt_q == 2'd0)
                        rdata_q <= read_data;
                    else
                        cnt_q <= cnt_q - 2'd1;
                end
                WR: rdata_q <= '0;
                default: ;
            endcase
        end
    end

    // stores always report zero, whatever an earlier load left behind
    assign rsp_rdata  = we_q ? '0 : rdata_q;
    assign mem_addr   = addr_q;
    assign write_data = wdata_q;

endmodule
